// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement subtractor.
// Computes d = x - y - b_in over WIDTH bits, one bit per clock, using one
// full-adder cell and a registered carry. Operands and results move over
// valid/ready handshakes. Only one operation is in flight at a time.
module serial_subtractor #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             b_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] d,
   output logic             b_out,
   output logic             overflow,
   output logic             zero
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic [WIDTH-1:0] x_sr;
   logic [WIDTH-1:0] y_sr;
   logic             x_msb;
   logic             y_msb;
   logic [WIDTH-1:0] res;

   logic             y_n;
   logic             sum;
   logic             cout;
   logic [WIDTH-1:0] res_next;

   // Handshake flags come straight from the state register.
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   // Full-adder cell: x + ~y + carry, with carry seeded as ~b_in.
   always_comb begin
      y_n      = ~y_sr[0];
      sum      = x_sr[0] ^ y_n ^ carry;
      cout     = (x_sr[0] & y_n) | (x_sr[0] & carry) | (y_n & carry);
      res_next = {sum, res[WIDTH-1:1]};
   end

   // Control: state sequencing, bit counter and carry register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         carry <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  state <= RUN;
                  cnt   <= '0;
                  carry <= ~b_in;
               end
            end
            RUN: begin
               carry <= cout;
               if (cnt == LAST) begin
                  state <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Datapath: operand capture, LSB-first shifting and result/flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_sr     <= '0;
         y_sr     <= '0;
         x_msb    <= 1'b0;
         y_msb    <= 1'b0;
         res      <= '0;
         d        <= '0;
         b_out    <= 1'b0;
         overflow <= 1'b0;
         zero     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  x_sr  <= x;
                  y_sr  <= y;
                  x_msb <= x[WIDTH-1];
                  y_msb <= y[WIDTH-1];
               end
            end
            RUN: begin
               x_sr <= x_sr >> 1;
               y_sr <= y_sr >> 1;
               res  <= res_next;
               if (cnt == LAST) begin
                  // The final sum bit is the result MSB, so flags use res_next.
                  d        <= res_next;
                  b_out    <= ~cout;
                  overflow <= (x_msb != y_msb) && (sum != x_msb);
                  zero     <= (res_next == '0);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed testbench for serial_subtractor (WIDTH = 32).
module tb_serial_subtractor;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] x;
   logic [31:0] y;
   logic        b_in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] d;
   logic        b_out;
   logic        overflow;
   logic        zero;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   serial_subtractor #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .y         (y),
      .b_in      (b_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .d         (d),
      .b_out     (b_out),
      .overflow  (overflow),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   // Global watchdog so the run can never hang.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Present operands in IDLE and let the accept edge happen.
   task automatic start_op(input string tag, input logic [31:0] xv, input logic [31:0] yv,
                           input logic bv);
      chk({tag, "_in_ready_idle"}, {31'b0, in_ready}, 32'd1);
      x        = xv;
      y        = yv;
      b_in     = bv;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk({tag, "_in_ready_run"}, {31'b0, in_ready}, 32'd0);
   endtask

   // Count edges after the accept edge until out_valid; expect 32.
   task automatic wait_done(input string tag, input bit toggle);
      int cyc = 0;
      while (out_valid !== 1'b1 && cyc < 100) begin
         if (toggle) begin
            x    = $urandom;
            y    = $urandom;
            b_in = 1'($urandom_range(0, 1));
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      chk({tag, "_latency"}, 32'(cyc), 32'd32);
   endtask

   task automatic check_result(input string tag, input logic [31:0] ed, input logic eb,
                               input logic eo, input logic ez);
      chk({tag, "_d"},        d,                 ed);
      chk({tag, "_b_out"},    {31'b0, b_out},    {31'b0, eb});
      chk({tag, "_overflow"}, {31'b0, overflow}, {31'b0, eo});
      chk({tag, "_zero"},     {31'b0, zero},     {31'b0, ez});
      chk({tag, "_in_ready_done"}, {31'b0, in_ready}, 32'd0);
   endtask

   task automatic release_op(input string tag);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({tag, "_out_valid_after"}, {31'b0, out_valid}, 32'd0);
      chk({tag, "_in_ready_after"},  {31'b0, in_ready},  32'd1);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      x         = '0;
      y         = '0;
      b_in      = 1'b0;

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_d",         d,                  32'd0);
      chk("rst_flags",     {29'b0, b_out, overflow, zero}, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("rel_in_ready",  {31'b0, in_ready},  32'd1);
      chk("rel_out_valid", {31'b0, out_valid}, 32'd0);

      // 5 - 3
      start_op("t1", 32'd5, 32'd3, 1'b0);
      wait_done("t1", 1'b0);
      check_result("t1", 32'h0000_0002, 1'b0, 1'b0, 1'b0);
      release_op("t1");

      // 0 - 1 wraps with borrow
      start_op("t2", 32'd0, 32'd1, 1'b0);
      wait_done("t2", 1'b0);
      check_result("t2", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
      release_op("t2");

      // most negative - 1: signed overflow
      start_op("t3", 32'h8000_0000, 32'd1, 1'b0);
      wait_done("t3", 1'b0);
      check_result("t3", 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
      release_op("t3");

      // 7 - 7 = 0
      start_op("t4", 32'd7, 32'd7, 1'b0);
      wait_done("t4", 1'b0);
      check_result("t4", 32'h0000_0000, 1'b0, 1'b0, 1'b1);
      release_op("t4");

      // 5 - 5 - 1 with inputs toggled during RUN
      start_op("t5", 32'd5, 32'd5, 1'b1);
      wait_done("t5", 1'b1);
      check_result("t5", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
      release_op("t5");

      // max positive - (-1): signed overflow and unsigned borrow
      start_op("t6", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      wait_done("t6", 1'b0);
      check_result("t6", 32'h8000_0000, 1'b1, 1'b1, 1'b0);
      release_op("t6");

      // Backpressure: result stays stable while out_ready is low.
      start_op("bp", 32'h1234_5678, 32'h0000_0078, 1'b0);
      wait_done("bp", 1'b0);
      for (int i = 0; i < 10; i++) begin
         x = $urandom;
         y = $urandom;
         in_valid = 1'b1;
         @(posedge clk);
         #1;
         chk("bp_out_valid_hold", {31'b0, out_valid}, 32'd1);
         chk("bp_in_ready_hold",  {31'b0, in_ready},  32'd0);
         chk("bp_d_hold",         d,                  32'h1234_5600);
      end
      in_valid = 1'b0;
      check_result("bp", 32'h1234_5600, 1'b0, 1'b0, 1'b0);
      release_op("bp");

      // Asynchronous reset in cycle 10 of RUN aborts the operation.
      start_op("ra", 32'hDEAD_BEEF, 32'h0000_0001, 1'b1);
      repeat (9) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("ra_out_valid", {31'b0, out_valid}, 32'd0);
      chk("ra_in_ready",  {31'b0, in_ready},  32'd1);
      chk("ra_d",         d,                  32'd0);
      chk("ra_flags",     {29'b0, b_out, overflow, zero}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      chk("ra_no_result", {31'b0, out_valid}, 32'd0);

      // Normal operation after the aborted one.
      start_op("t7", 32'd100, 32'd58, 1'b0);
      wait_done("t7", 1'b0);
      check_result("t7", 32'd42, 1'b0, 1'b0, 1'b0);
      release_op("t7");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor: computes D = X − Y − B_IN over WIDTH bits, one bit per clock, using a single full-adder cell and a registered carry/borrow. It is the area-minimal counterpart to the parallel 32-bit adder in the arithmetic datapath. Operands are accepted and results returned through valid/ready handshakes, so it drops into the same operand/result plumbing as the existing arithmetic blocks.

## Interface
- WIDTH, 32, operand and result width in bits (≥ 2).
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operands present on x, y, b_in.
- in_ready  output  1  block can accept operands; high only in IDLE.
- x  input  WIDTH  minuend.
- y  input  WIDTH  subtrahend.
- b_in  input  1  borrow-in.
- out_valid  output  1  result present; high only in DONE.
- out_ready  input  1  consumer accepts result.
- d  output  WIDTH  difference, (x − y − b_in) mod 2^WIDTH.
- b_out  output  1  borrow-out: 1 iff unsigned x < y + b_in.
- overflow  output  1  signed overflow of x − y − b_in.
- zero  output  1  d == 0.

## Operation
- States: IDLE, RUN, DONE. Reset state IDLE.
- IDLE: in_ready=1. On in_valid && in_ready, capture x, y, b_in into shift registers; carry register ← ~b_in; bit counter ← 0; go to RUN.
- RUN: each cycle, for bit i = counter: sum = x[i] ^ ~y[i] ^ carry; carry ← majority(x[i], ~y[i], carry). The sum bit shifts into the result register at MSB, LSB first. Counter increments. After bit WIDTH−1, go to DONE.
- On entry to DONE: d = full result register; b_out = ~final carry; overflow = (x[W−1] ≠ y[W−1]) && (d[W−1] ≠ x[W−1]) using captured operands; zero = (d == 0). All result outputs are registered.
- DONE: out_valid=1; d/b_out/overflow/zero held stable while out_ready=0. On out_ready, go to IDLE.
- d, b_out, overflow and zero keep their last values after the handshake, until the next DONE. They are meaningful only when out_valid=1.
- Input ports are ignored outside the IDLE accept cycle. Changes to x/y during RUN do not affect the result.
- b_in=1 with x == y yields d = all ones, b_out=1, overflow=0.

## Timing
- Reset values, asserted and on release: state IDLE, in_ready=1, out_valid=0, d=0, b_out=0, overflow=0, zero=0, carry=0, counter=0.
- Reset mid-RUN or mid-DONE aborts the operation immediately (asynchronous). The pending result is discarded and no out_valid is produced.
- Latency: accept edge at cycle 0. RUN occupies cycles 1..WIDTH. out_valid rises after the edge ending cycle WIDTH, so it is first sampled high in cycle WIDTH+1 (33 for WIDTH=32).
- in_ready is derived from the state register only, with no combinational path from in_valid or out_ready.
- DONE→IDLE on the out_ready edge. in_ready is high the following cycle; the same cycle cannot accept a new operation. Minimum issue interval is WIDTH+2 cycles with out_ready held high.
- No pipelining: only one operation is in flight. in_ready=0 throughout RUN and DONE.
- The counter is ⌈log2 WIDTH⌉ bits and does not wrap within an operation. The RUN exit compare is against WIDTH−1.

## Test plan
- Reset then x=5, y=3, b_in=0 → out_valid in cycle 33; d=0x00000002, b_out=0, overflow=0, zero=0.
- x=0, y=1, b_in=0 → d=0xFFFFFFFF, b_out=1, overflow=0, zero=0.
- x=0x80000000, y=1 → d=0x7FFFFFFF, overflow=1, b_out=0. Also x=7, y=7 → d=0, zero=1, b_out=0.
- x=5, y=5, b_in=1 → d=0xFFFFFFFF, b_out=1, overflow=0. Toggle x/y randomly during RUN; the result is unchanged.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. d and flags stay stable, in_ready stays 0. out_ready=1 → IDLE, then in_ready=1 next cycle.
- Assert rst at cycle 10 of RUN → out_valid=0 and in_ready=1 immediately, all outputs 0. After release, x=100, y=58 → d=42 after 33 cycles.
